uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer sitting directly downstream of the UART receiver. Captures each completed frame (8 data bits plus parity-error and stop-error flags) on the rising edge of the receiver's valid output. Holds frames in a circular FIFO until the host side pops them. Decouples frame arrival from host read latency and reports overflow.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- One clock; reset is synchronous and active-high. Ports are clk and reset.
- clk  in  1  system clock; same clock as the receiver.
- reset  in  1  synchronous, active-high reset.
- RX_Data  in  8  received byte from the receiver.
- Valid_rx  in  1  frame-complete level from the receiver; may stay high for several cycles per frame.
- Parity_error  in  1  parity flag for the current frame.
- Stop_error  in  1  stop-bit flag for the current frame.
- rd_en  in  1  pop request from the host.
- ovf_clr  in  1  clears the sticky overflow flag.
- rd_data  out  8  byte at the head of the FIFO.
- rd_parity_err  out  1  parity flag of the head entry.
- rd_stop_err  out  1  stop flag of the head entry.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  ADDR_W+1  current occupancy, 0 to DEPTH.
- overflow  out  1  sticky: a frame was lost because the FIFO was full.

## Operation
- Edge detect: register valid_q <= Valid_rx. wr_stb = Valid_rx & ~valid_q. Exactly one write per Valid_rx high period, however long it lasts.
- Write: on wr_stb, store {Stop_error, Parity_error, RX_Data} at wr_ptr, then increment wr_ptr modulo DEPTH.
- Read: first-word-fall-through. rd_data and both rd_*_err flags always show mem[rd_ptr]. When rd_en=1 and empty=0, rd_ptr increments modulo DEPTH. When empty=1, rd_en is ignored and no flag is raised.
- Count: count += wr_accept − rd_accept. empty = (count==0). full = (count==DEPTH).
- Full and wr_stb without a read: the frame is dropped, overflow is set, and count is unchanged.
- Full with simultaneous wr_stb and rd_en: both are accepted; count stays at DEPTH; overflow is not set.
- Empty with simultaneous wr_stb and rd_en: the read is ignored and the write is accepted; count becomes 1.
- Overflow clear: ovf_clr=1 clears overflow. If a drop happens in the same cycle, set wins.
- Pointer wrap: the pointers are ADDR_W bits wide and wrap naturally. Occupancy comes from count only, not from pointer comparison.
- Reset mid-operation discards all stored entries. Memory contents are not cleared, but outputs are masked (see Timing).

## Timing
- Reset values:
  - count=0, empty=1, full=0, overflow=0.
  - wr_ptr=0, rd_ptr=0, valid_q=0.
  - rd_data=0, rd_parity_err=0, rd_stop_err=0; these read outputs are forced to 0 whenever empty=1.
- Write latency: if wr_stb is high in cycle N, the entry is written at the end-of-N edge. In cycle N+1, empty=0, count has incremented, and rd_data shows the entry if the FIFO was previously empty.
- Read: rd_en sampled high at an edge advances the head. The next entry (or 0 with empty=1) appears in the following cycle.
- Valid_rx high during reset: valid_q resets to 0. A Valid_rx still high on the first cycle after reset produces one write.
- All outputs are registered or decoded from registered state. There is no combinational path from Valid_rx to any output.

## Configuration
- UART_RX_FIFO_DROP_ERR_EN defined: frames with Stop_error=1 at wr_stb are discarded. No write occurs, count is unchanged, and overflow is untouched. The rd_stop_err output is tied to 0.
- Undefined: every frame is stored with both error flags, and rd_stop_err reflects the stored flag.

## Structure
- Shared package uart_pkg holds:
  - UART_DATA_W = 8;
  - typedef rx_entry_t, a packed struct {stop_err, parity_err, data[7:0]}. Total width 10 bits, also used by the receiver and the host register block.
- Sub-module uart_fifo_mem: DEPTH×10 register array with a synchronous write port and an asynchronous read port. It is instantiated once.
- Top level holds the edge detect, pointers, count, flags and output masking.

## Test plan
- Single frame: RX_Data=0xA5, errors 0, Valid_rx high 3 cycles. Expect exactly one write: count=1, rd_data=0xA5. Then rd_en 1 cycle gives empty=1, rd_data=0.
- Fill and overflow (DEPTH=16): send frames 0x00..0x10 (17 frames) with no reads. Expect full=1, count=16, overflow=1. Popping all returns 0x00..0x0F in order; 0x10 is lost. Then ovf_clr gives overflow=0.
- Simultaneous full read/write: with full=1, apply wr_stb (0x3C) and rd_en in the same cycle. Expect count=16, overflow=0, and 0x3C as the last entry popped.
- Error flags: a frame 0x55 with Parity_error=1 is stored with rd_parity_err=1. A frame 0x66 with Stop_error=1 is stored with rd_stop_err=1 when the macro is undefined, and is absent (count unchanged) when UART_RX_FIFO_DROP_ERR_EN is defined.
- Wrap-around: 40 frames interleaved with reads keeping occupancy 1–3. Data order is preserved across pointer wrap, and count never exceeds 3.
- Reset mid-operation: 5 entries stored, reset for 1 cycle while Valid_rx=1. Expect count=0, empty=1, rd_data=0. The next cycle, with Valid_rx still high, gives count=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: the received-frame record used by the receiver, the RX FIFO and the
// host register block.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef struct packed {
    logic                   stop_err;
    logic                   parity_err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

  localparam int unsigned RX_ENTRY_W = $bits(rx_entry_t);

  function automatic rx_entry_t make_entry(input logic [UART_DATA_W-1:0] data,
                                           input logic parity_err, input logic stop_err);
    rx_entry_t e;
    e.data       = data;
    e.parity_err = parity_err;
    e.stop_err   = stop_err;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and host-side signals of the UART RX FIFO. The master modport is the
// environment (receiver plus host); the slave modport is the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  import uart_pkg::*;

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] RX_Data;
  logic                   Valid_rx;
  logic                   Parity_error;
  logic                   Stop_error;
  logic                   rd_en;
  logic                   ovf_clr;

  logic [UART_DATA_W-1:0] rd_data;
  logic                   rd_parity_err;
  logic                   rd_stop_err;
  logic                   empty;
  logic                   full;
  logic [ADDR_W:0]        count;
  logic                   overflow;

  modport master (
    output RX_Data, Valid_rx, Parity_error, Stop_error, rd_en, ovf_clr,
    input  rd_data, rd_parity_err, rd_stop_err, empty, full, count, overflow
  );

  modport slave (
    input  RX_Data, Valid_rx, Parity_error, Stop_error, rd_en, ovf_clr,
    output rd_data, rd_parity_err, rd_stop_err, empty, full, count, overflow
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x rx_entry_t register array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the FIFO masks stale data while empty.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  rx_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output rx_entry_t                rdata
);

  rx_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: one write per rising edge of Valid_rx, first-word-fall-through reads,
// sticky overflow. Define UART_RX_FIFO_DROP_ERR_EN to discard frames carrying a stop error.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic              valid_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              wr_stb;
  logic              frame_keep;
  logic              wr_accept;
  logic              rd_accept;
  logic              drop;
  logic              empty;
  logic              full;
  rx_entry_t         wr_entry;
  rx_entry_t         head;

  assign empty = (count_q == '0);
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));

  assign wr_stb = bus.Valid_rx & ~valid_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign frame_keep = ~bus.Stop_error;
`else
  assign frame_keep = 1'b1;
`endif

  // A pop while full frees the slot the simultaneous write lands in.
  assign rd_accept = bus.rd_en & ~empty;
  assign wr_accept = wr_stb & frame_keep & (~full | rd_accept);
  assign drop      = wr_stb & frame_keep & full & ~rd_accept;

  assign wr_entry = make_entry(bus.RX_Data, bus.Parity_error, bus.Stop_error);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= bus.Valid_rx;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept & ~reset),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // Read outputs are masked while empty so stale memory never leaks out.
  assign bus.rd_data       = empty ? '0 : head.data;
  assign bus.rd_parity_err = empty ? 1'b0 : head.parity_err;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign bus.rd_stop_err   = 1'b0;
`else
  assign bus.rd_stop_err   = empty ? 1'b0 : head.stop_err;
`endif
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state: the queue holds frames in arrival order.
  rx_entry_t m_q[$];
  bit        m_vprev = 1'b0;
  bit        m_ovf   = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT state against the model, then advance the model with the inputs
  // that the coming rising edge will sample.
  always @(negedge clk) begin
    logic [7:0] e_data;
    logic       e_pe, e_se;
    bit         stb, keep, rd, acc;
    e_data = 8'h00; e_pe = 1'b0; e_se = 1'b0;
    if (m_q.size() > 0) begin
      e_data = m_q[0].data;
      e_pe   = m_q[0].parity_err;
`ifndef UART_RX_FIFO_DROP_ERR_EN
      e_se   = m_q[0].stop_err;
`endif
    end
    check("count", 16'(bus.count), 16'(m_q.size()));
    check("empty", 16'(bus.empty), 16'(m_q.size() == 0));
    check("full", 16'(bus.full), 16'(m_q.size() == DEPTH));
    check("overflow", 16'(bus.overflow), 16'(m_ovf));
    check("rd_data", 16'(bus.rd_data), 16'(e_data));
    check("rd_parity_err", 16'(bus.rd_parity_err), 16'(e_pe));
    check("rd_stop_err", 16'(bus.rd_stop_err), 16'(e_se));

    if (reset) begin
      m_q.delete();
      m_vprev = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      stb = bus.Valid_rx && !m_vprev;
      m_vprev = bus.Valid_rx;
`ifdef UART_RX_FIFO_DROP_ERR_EN
      keep = !bus.Stop_error;
`else
      keep = 1'b1;
`endif
      rd  = bus.rd_en && (m_q.size() > 0);
      acc = 1'b0;
      if (stb && keep) begin
        if (m_q.size() < DEPTH || rd) acc = 1'b1;
      end
      if (rd) void'(m_q.pop_front());
      if (acc) m_q.push_back(make_entry(bus.RX_Data, bus.Parity_error, bus.Stop_error));
      if (stb && keep && !acc) m_ovf = 1'b1;
      else if (bus.ovf_clr)    m_ovf = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Valid_rx = 1'b0;
    bus.rd_en    = 1'b0;
    bus.ovf_clr  = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic se,
                      input int hold, input int gap);
    bus.RX_Data      = d;
    bus.Parity_error = pe;
    bus.Stop_error   = se;
    bus.Valid_rx     = 1'b1;
    repeat (hold) tick();
    bus.Valid_rx     = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pop(input int n);
    bus.rd_en = 1'b1;
    repeat (n) tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    int bias;
    reset = 1'b1;
    bus.RX_Data = 8'h00; bus.Parity_error = 1'b0; bus.Stop_error = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single frame held for three cycles, then one pop.
    send(8'hA5, 1'b0, 1'b0, 3, 1);
    pop(1);
    tick();

    // Fill past capacity, drain, clear overflow.
    for (int i = 0; i <= 16; i++) send(8'(i), 1'b0, 1'b0, 1, 1);
    pop(16);
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;

    // Simultaneous write and read while full.
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b0, 1'b0, 1, 1);
    bus.rd_en = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 1, 0);
    bus.rd_en = 1'b0;
    tick();
    pop(16);

    // Write into an empty FIFO with a concurrent (ignored) read.
    bus.rd_en = 1'b1;
    send(8'h11, 1'b0, 1'b0, 1, 0);
    bus.rd_en = 1'b0;
    tick();

    // Error flags.
    send(8'h55, 1'b1, 1'b0, 2, 1);
    send(8'h66, 1'b0, 1'b1, 2, 1);
    pop(3);

    // Wrap-around with occupancy held at two.
    send(8'hF0, 1'b0, 1'b0, 1, 1);
    send(8'hF1, 1'b0, 1'b0, 1, 1);
    for (int i = 0; i < 40; i++) begin
      bus.rd_en = 1'b1;
      send(8'($urandom), 1'b0, 1'b0, 1, 0);
      bus.rd_en = 1'b0;
      tick();
    end
    pop(2);

    // Reset mid-operation with Valid_rx held high.
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 1'b0, 1'b0, 1, 1);
    bus.RX_Data = 8'h99; bus.Valid_rx = 1'b1;
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    tick();
    idle(); tick();
    pop(2);

    // Random traffic with shifting read pressure.
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 90 : 50);
      if (bus.Valid_rx && ($urandom % 3 == 0)) begin
        bus.Valid_rx = 1'b0;
      end else if (!bus.Valid_rx && ($urandom % 4 == 0)) begin
        bus.RX_Data      = 8'($urandom);
        bus.Parity_error = ($urandom % 8 == 0);
        bus.Stop_error   = ($urandom % 8 == 0);
        bus.Valid_rx     = 1'b1;
      end
      bus.rd_en   = (($urandom % 100) < bias);
      bus.ovf_clr = ($urandom % 50 == 0);
      reset       = ($urandom % 500 == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick(); tick();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
